i2c_slave_mb: RTL and testbench
===============================

// Module: i2c_slave_mb
// PURPOSE
//  Parametrised I2C target (slave) supporting multi-byte write AND read transfers, repeated START,
//  NACK on address mismatch / overflow. Successor of the fixed 12-bit write-only slave; sits between
//  the board-level open-drain SCL/SDA pins and a parallel register interface in the system fabric.
//  Oversamples SCL/SDA on the system clock; no clock stretching.
// PARAMETERS
//  SLAVE_ADDR   7'd52  7-bit target address matched after START
//  NUM_BYTES    2      bytes per transfer (write payload and read payload), >=1
//  SYNC_STAGES  2      synchroniser flops on SCL/SDA, >=2
// PORTS
//  clk        in     1              system clock; all logic on rising edge
//  rst        in     1              synchronous, active-high reset
//  scl        in     1              I2C clock from controller (async)
//  sda        inout  1              I2C data, open-drain: drives 0 or 'z'
//  tx_data    in     NUM_BYTES*8    read payload; byte 0 = [MSB:MSB-7], sampled at address ACK of a read
//  rx_data    out    NUM_BYTES*8    last complete write payload, byte 0 in MSBs
//  rx_valid   out    1              1-cycle pulse: complete write payload committed to rx_data
//  rd_done    out    1              1-cycle pulse: read transfer finished (controller NACK)
//  busy       out    1              high from addressed START until STOP/mismatch
//  byte_cnt   out    $clog2(NUM_BYTES+1)  bytes transferred in current transfer
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state IDLE, sda released ('z'), rx_data=0, rx_valid=0, rd_done=0,
//   busy=0, byte_cnt=0, shift/bit counters 0. Reset mid-transfer releases SDA next cycle.
//  Line events (after SYNC_STAGES): START = SDA fall while SCL high; STOP = SDA rise while SCL high;
//   data sampled on SCL rise; target changes SDA only on SCL fall. Event latency SYNC_STAGES+1 clk.
//  START/repeated START in ANY state -> ADDR, bit_cnt=0, byte_cnt=0, SDA released; STOP in any state
//   -> IDLE. START and STOP have priority over the state-machine next state.
//  States:
//   IDLE      wait for START.
//   ADDR      shift 8 bits MSB first; on 8th bit's SCL fall: addr[7:1]==SLAVE_ADDR -> drive 0, ADDR_ACK,
//             else release SDA -> WAIT_STOP (no ACK).
//   ADDR_ACK  on SCL fall: R/W=0 -> release, WR_DATA; R/W=1 -> load tx_data into shadow, drive
//             bit7 of byte 0, RD_DATA. busy=1 from here.
//   WR_DATA   shift 8 bits; on 8th SCL fall: if byte_cnt<NUM_BYTES store byte in staging reg at
//             index byte_cnt, byte_cnt++, drive ACK -> WR_ACK; else NACK (release) -> WAIT_STOP.
//   WR_ACK    on SCL fall release SDA -> WR_DATA.
//   RD_DATA   drive shadow bits MSB first, next bit on each SCL fall; after 8th bit's SCL fall release
//             SDA, byte_cnt++ -> RD_ACK.
//   RD_ACK    sample controller ACK at SCL rise; ACK(0) and byte_cnt<NUM_BYTES -> next byte; ACK with
//             byte_cnt==NUM_BYTES -> send 8'hFF (SDA released); NACK(1) -> rd_done pulse, WAIT_STOP.
//   WAIT_STOP SDA released, ignore bits until START/STOP.
//  Commit: on STOP or repeated START following a write with byte_cnt==NUM_BYTES, staging -> rx_data and
//   rx_valid pulses 1 cycle. Partial writes (byte_cnt<NUM_BYTES) are discarded, rx_data unchanged.
//  Simultaneous START/STOP with SCL edge: START/STOP wins, edge ignored.
//  Glitch-free: sda output register only; sda = sda_oe ? 1'b0 : 1'bz.
// STRUCTURE
//  i2c_pkg: typedef enum i2c_state_t {IDLE,ADDR,ADDR_ACK,WR_DATA,WR_ACK,RD_DATA,RD_ACK,WAIT_STOP};
//   localparam I2C_RW_WRITE=1'b0, I2C_RW_READ=1'b1.
//  Sub-module i2c_line_sync: SYNC_STAGES synchronisers + edge detect; outputs scl_rise, scl_fall,
//   start_det, stop_det, sda_s. Top holds FSM, counters, staging/shadow registers.
// TESTING
//  1 Write 0x68,0xA5,0x3C,STOP (addr 52, NUM_BYTES=2) -> 3 ACKs, rx_data=16'hA53C, rx_valid 1 pulse.
//  2 Address 0x55 write -> no ACK (SDA high at 9th clock), busy=0, rx_data unchanged, no rx_valid.
//  3 Read 0x69, tx_data=16'hBEEF, ACK,NACK,STOP -> SDA bytes 0xBE,0xEF, rd_done 1 pulse.
//  4 Write 0x68,0x11, repeated START, read 0x69 -> partial write discarded (no rx_valid), read OK.
//  5 Write 3 data bytes (NUM_BYTES=2) -> 3rd byte NACKed, rx_valid at STOP, rx_data=first 2 bytes.
//  6 rst=1 while target drives ACK low -> SDA released next clk, all outputs at reset values.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the multi-byte I2C target.
// The state encoding is also visible on the top-level dbg_state port.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        WR_DATA   = 3'd3,
        WR_ACK    = 3'd4,
        RD_DATA   = 3'd5,
        RD_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } i2c_state_t;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    localparam logic [3:0] I2C_BYTE_BITS = 4'd8;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises SCL/SDA into the clk domain and derives single-cycle line events.
// The synchroniser flops reset to 1, which matches an idle, pulled-up bus.
module i2c_line_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic                   scl_s;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_prev_d = scl_sync_q[SYNC_STAGES-1];
        sda_prev_d = sda_sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // START/STOP need SCL high on both samples so an SCL edge never aliases as one.
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_slave_mb.sv
// Multi-byte I2C target: address match, NUM_BYTES write/read payloads, repeated START.
// SDA is only ever pulled low from a register; the pin is released otherwise.
module i2c_slave_mb
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'd52,
    parameter int         NUM_BYTES   = 2,
    parameter int         SYNC_STAGES = 2,
    localparam int        W           = NUM_BYTES * 8,
    localparam int        CW          = $clog2(NUM_BYTES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl,
    inout  wire           sda,
    input  logic [W-1:0]  tx_data,
    output logic [W-1:0]  rx_data,
    output logic          rx_valid,
    output logic          rd_done,
    output logic          busy,
    output logic [CW-1:0] byte_cnt,
    output logic [2:0]    dbg_state
);

    localparam logic [CW-1:0] NB = CW'(NUM_BYTES);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_state_t   state_q, state_d;
    logic [3:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   shift_q, shift_d;
    logic [CW-1:0] byte_cnt_q, byte_cnt_d;
    logic [W-1:0] staging_q, staging_d;
    logic [W-1:0] shadow_q, shadow_d;
    logic [W-1:0] rx_data_q, rx_data_d;
    logic         rx_valid_q, rx_valid_d;
    logic         rd_done_q, rd_done_d;
    logic         busy_q, busy_d;
    logic         sda_oe_q, sda_oe_d;
    logic         wr_flag_q, wr_flag_d;
    logic         ack_q, ack_d;
    logic         commit;

    i2c_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda_in    (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    assign commit = wr_flag_q && (byte_cnt_q == NB);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        staging_d  = staging_q;
        shadow_d   = shadow_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rd_done_d  = 1'b0;
        busy_d     = busy_q;
        sda_oe_d   = sda_oe_q;
        wr_flag_d  = wr_flag_q;
        ack_d      = ack_q;

        if (start_det || stop_det) begin
            if (commit) begin
                rx_data_d  = staging_q;
                rx_valid_d = 1'b1;
            end
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            wr_flag_d = 1'b0;
            if (start_det) begin
                state_d    = ADDR;
                bit_cnt_d  = 4'd0;
                byte_cnt_d = '0;
            end else begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == I2C_BYTE_BITS) begin
                        bit_cnt_d = 4'd0;
                        if (shift_q[7:1] == SLAVE_ADDR) begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            state_d  = ADDR_ACK;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (shift_q[0] == I2C_RW_WRITE) begin
                            sda_oe_d  = 1'b0;
                            wr_flag_d = 1'b1;
                            state_d   = WR_DATA;
                        end else begin
                            // Shifting 1s in behind the payload yields 8'hFF once it is exhausted.
                            shadow_d  = {tx_data[W-2:0], 1'b1};
                            sda_oe_d  = ~tx_data[W-1];
                            bit_cnt_d = 4'd1;
                            state_d   = RD_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == I2C_BYTE_BITS) begin
                        bit_cnt_d = 4'd0;
                        if (byte_cnt_q < NB) begin
                            for (int i = 0; i < NUM_BYTES; i++) begin
                                if (byte_cnt_q == CW'(i)) begin
                                    staging_d[(NUM_BYTES-1-i)*8 +: 8] = shift_q;
                                end
                            end
                            byte_cnt_d = byte_cnt_q + 1'b1;
                            sda_oe_d   = 1'b1;
                            state_d    = WR_ACK;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = WAIT_STOP;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = WR_DATA;
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == I2C_BYTE_BITS) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            ack_d     = 1'b0;
                            if (byte_cnt_q < NB) begin
                                byte_cnt_d = byte_cnt_q + 1'b1;
                            end
                            state_d = RD_ACK;
                        end else begin
                            sda_oe_d  = ~shadow_q[W-1];
                            shadow_d  = {shadow_q[W-2:0], 1'b1};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            ack_d = 1'b1;
                        end else begin
                            rd_done_d = 1'b1;
                            state_d   = WAIT_STOP;
                        end
                    end else if (scl_fall && ack_q) begin
                        ack_d     = 1'b0;
                        sda_oe_d  = ~shadow_q[W-1];
                        shadow_d  = {shadow_q[W-2:0], 1'b1};
                        bit_cnt_d = 4'd1;
                        state_d   = RD_DATA;
                    end
                end
                WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'd0;
            byte_cnt_q <= '0;
            staging_q  <= '0;
            shadow_q   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rd_done_q  <= 1'b0;
            busy_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            wr_flag_q  <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            staging_q  <= staging_d;
            shadow_q   <= shadow_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rd_done_q  <= rd_done_d;
            busy_q     <= busy_d;
            sda_oe_q   <= sda_oe_d;
            wr_flag_q  <= wr_flag_d;
            ack_q      <= ack_d;
        end
    end

    assign sda       = sda_oe_q ? 1'b0 : 1'bz;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rd_done   = rd_done_q;
    assign busy      = busy_q;
    assign byte_cnt  = byte_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_slave_mb.sv
// Directed bench: a bit-banged I2C controller drives the target; payload pulses are
// checked against an expected queue by a separate monitor.
module tb_i2c_slave_mb;

    logic        clk = 1'b0;
    logic        rst;
    logic        scl;
    logic        sda_m;
    wire         sda;
    logic [15:0] tx_data;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rd_done;
    logic        busy;
    logic [1:0]  byte_cnt;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    // Valid/ready-style contract: rx_valid qualifies rx_data for one cycle; rd_done is a bare pulse.
    logic [15:0] exp_q[$];
    logic [0:0]  exp_rd_q[$];

    assign sda = sda_m ? 1'bz : 1'b0;
    pullup (sda);

    i2c_slave_mb dut (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda       (sda),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rd_done   (rd_done),
        .busy      (busy),
        .byte_cnt  (byte_cnt),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                if (exp_q.size() == 0) check("rx_valid_unexpected", {31'd0, rx_valid}, 32'd0);
                else check("rx_data", {16'd0, rx_data}, {16'd0, exp_q.pop_front()});
            end
            if (rd_done) begin
                if (exp_rd_q.size() == 0) check("rd_done_unexpected", {31'd0, rd_done}, 32'd0);
                else check("rd_done", {31'd0, rd_done}, {31'd0, exp_rd_q.pop_front()});
            end
        end
    end

    task automatic wait_q;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic bit_out(input logic b, output logic seen);
        sda_m = b;
        wait_q;
        scl = 1'b1;
        wait_q;
        seen = (sda === 1'b0) ? 1'b0 : 1'b1;
        wait_q;
        scl = 1'b0;
        wait_q;
    endtask

    task automatic send8(input logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) bit_out(b[i], s);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        send8(b);
        bit_out(1'b1, ack);
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_out(1'b1, s);
            b[i] = s;
        end
        bit_out(ack_bit, s);
    endtask

    task automatic start_c;
        sda_m = 1'b1;
        wait_q;
        scl = 1'b1;
        wait_q;
        sda_m = 1'b0;
        wait_q;
        scl = 1'b0;
        wait_q;
    endtask

    task automatic stop_c;
        sda_m = 1'b0;
        wait_q;
        scl = 1'b1;
        wait_q;
        sda_m = 1'b1;
        wait_q;
        wait_q;
    endtask

    initial begin
        logic       ack;
        logic [7:0] rb;

        rst     = 1'b1;
        scl     = 1'b1;
        sda_m   = 1'b1;
        tx_data = 16'h0000;
        repeat (5) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rx_data", {16'd0, rx_data}, 32'd0);
        check("rst_byte_cnt", {30'd0, byte_cnt}, 32'd0);
        check("rst_sda", {31'd0, sda}, 32'd1);
        check("rst_state", {29'd0, dbg_state}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_q;

        // 1: full two-byte write
        start_c;
        write_byte(8'h68, ack);
        check("t1_addr_ack", {31'd0, ack}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd1);
        write_byte(8'hA5, ack);
        check("t1_d0_ack", {31'd0, ack}, 32'd0);
        check("t1_cnt1", {30'd0, byte_cnt}, 32'd1);
        write_byte(8'h3C, ack);
        check("t1_d1_ack", {31'd0, ack}, 32'd0);
        check("t1_cnt2", {30'd0, byte_cnt}, 32'd2);
        exp_q.push_back(16'hA53C);
        stop_c;
        check("t1_busy_after", {31'd0, busy}, 32'd0);
        check("t1_rx_data", {16'd0, rx_data}, 32'h0000A53C);

        // 2: foreign address 0x55 (write) is not acknowledged
        start_c;
        write_byte(8'hAA, ack);
        check("t2_addr_nack", {31'd0, ack}, 32'd1);
        check("t2_busy", {31'd0, busy}, 32'd0);
        stop_c;
        check("t2_rx_data", {16'd0, rx_data}, 32'h0000A53C);

        // 3: two-byte read ending in NACK
        tx_data = 16'hBEEF;
        start_c;
        write_byte(8'h69, ack);
        check("t3_addr_ack", {31'd0, ack}, 32'd0);
        check("t3_busy", {31'd0, busy}, 32'd1);
        read_byte(1'b0, rb);
        check("t3_byte0", {24'd0, rb}, 32'h000000BE);
        exp_rd_q.push_back(1'b1);
        read_byte(1'b1, rb);
        check("t3_byte1", {24'd0, rb}, 32'h000000EF);
        stop_c;

        // 4: partial write dropped by repeated START, then a read
        tx_data = 16'h1234;
        start_c;
        write_byte(8'h68, ack);
        check("t4_addr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h11, ack);
        check("t4_d0_ack", {31'd0, ack}, 32'd0);
        start_c;
        write_byte(8'h69, ack);
        check("t4_raddr_ack", {31'd0, ack}, 32'd0);
        exp_rd_q.push_back(1'b1);
        read_byte(1'b1, rb);
        check("t4_rbyte", {24'd0, rb}, 32'h00000012);
        stop_c;
        check("t4_rx_data", {16'd0, rx_data}, 32'h0000A53C);

        // 5: overflow byte is NACKed, first two bytes committed
        start_c;
        write_byte(8'h68, ack);
        write_byte(8'hC3, ack);
        check("t5_d0_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h7E, ack);
        check("t5_d1_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h99, ack);
        check("t5_d2_nack", {31'd0, ack}, 32'd1);
        exp_q.push_back(16'hC37E);
        stop_c;
        check("t5_rx_data", {16'd0, rx_data}, 32'h0000C37E);

        // 6: reset while the target holds the address ACK low
        start_c;
        send8(8'h68);
        sda_m = 1'b1;
        wait_q;
        check("t6_ack_driven", {31'd0, sda}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_sda_released", {31'd0, sda}, 32'd1);
        check("t6_busy_rst", {31'd0, busy}, 32'd0);
        check("t6_rx_data_rst", {16'd0, rx_data}, 32'd0);
        check("t6_cnt_rst", {30'd0, byte_cnt}, 32'd0);
        check("t6_state_rst", {29'd0, dbg_state}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_q;
        scl = 1'b1;
        wait_q;

        // 7: target is usable again after reset
        start_c;
        write_byte(8'h68, ack);
        check("t7_addr_ack", {31'd0, ack}, 32'd0);
        write_byte(8'h01, ack);
        write_byte(8'h02, ack);
        check("t7_d1_ack", {31'd0, ack}, 32'd0);
        exp_q.push_back(16'h0102);
        stop_c;
        check("t7_rx_data", {16'd0, rx_data}, 32'h00000102);

        wait_q;
        check("exp_q_empty", exp_q.size(), 32'd0);
        check("exp_rd_q_empty", exp_rd_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
